// File: rtl/regfile_write_queue.sv
// Write-side front end for the 32x32 register file. Accepts results from the
// ALU (port A) and the load/mem unit (port B) and holds them in a small
// in-order FIFO. It drains one register write per cycle and offers two
// combinational forwarding lookups over the entries still queued.
module regfile_write_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  output logic          b_ready,
  output logic          wr_enb,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  input  logic [AW-1:0] q1_addr,
  output logic          q1_hit,
  output logic [DW-1:0] q1_data,
  input  logic [AW-1:0] q2_addr,
  output logic          q2_hit,
  output logic [DW-1:0] q2_data,
  output logic [CW-1:0] count,
  output logic          empty
);

  localparam logic [CW:0] FREE_ONE = (CW+1)'(1);
  localparam logic [CW:0] FREE_TWO = (CW+1)'(2);

  // Queue storage; contents are qualified by count, so it carries no reset.
  logic [AW-1:0] addr_mem_q [DEPTH];
  logic [DW-1:0] data_mem_q [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          empty_c;
  logic          pop;
  logic [CW:0]   free;
  logic          a_push;
  logic          b_push;
  logic [PW-1:0] b_slot;

  assign empty_c = (count_q == '0);
  assign count   = count_q;
  assign empty   = empty_c;

  // The register file never back-pressures, so the head drains whenever
  // anything is queued. The write is suppressed while reset discards the queue.
  assign pop     = !empty_c;
  assign wr_enb  = pop && !rst;
  assign wr_addr = wr_enb ? addr_mem_q[head_q] : '0;
  assign wr_data = wr_enb ? data_mem_q[head_q] : '0;

  // Free slots include the one vacated by this cycle's pop.
  assign free = (CW+1)'(DEPTH) - {1'b0, count_q} + (empty_c ? '0 : FREE_ONE);

  // A has priority for the last slot; B only needs a second slot when A
  // actually occupies one (register 0 results never occupy a slot).
  assign a_ready = (free >= FREE_ONE);
  assign a_push  = a_valid && a_ready && (a_addr != '0);
  assign b_ready = (free >= FREE_TWO) || ((free >= FREE_ONE) && !a_push);
  assign b_push  = b_valid && b_ready && (b_addr != '0);

  // B lands behind A when both are pushed in the same cycle.
  assign b_slot = tail_q + PW'(a_push);

  // Next-state pointer and occupancy arithmetic; pointers wrap modulo DEPTH.
  always_comb begin
    head_d  = head_q + PW'(pop);
    tail_d  = tail_q + PW'(a_push) + PW'(b_push);
    count_d = count_q + CW'(a_push) + CW'(b_push) - CW'(pop);
  end

  // Control state: pointers and occupancy, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage writes at the tail, A first then B.
  always_ff @(posedge clk) begin
    if (!rst && a_push) begin
      addr_mem_q[tail_q] <= a_addr;
      data_mem_q[tail_q] <= a_data;
    end
    if (!rst && b_push) begin
      addr_mem_q[b_slot] <= b_addr;
      data_mem_q[b_slot] <= b_data;
    end
  end

  // Forwarding: scan from head (oldest) to tail (newest) so the last match wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx     = '0;
    q1_hit  = 1'b0;
    q1_data = '0;
    q2_hit  = 1'b0;
    q2_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (CW'(i) < count_q) begin
        if ((q1_addr != '0) && (addr_mem_q[idx] == q1_addr)) begin
          q1_hit  = 1'b1;
          q1_data = data_mem_q[idx];
        end
        if ((q2_addr != '0) && (addr_mem_q[idx] == q2_addr)) begin
          q2_hit  = 1'b1;
          q2_data = data_mem_q[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_queue.sv
// Bench for regfile_write_queue: a driver issues directed vectors and pushes
// each expected register write into a scoreboard queue; a monitor pops and
// compares whenever the DUT presents a write.
module tb_regfile_write_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_valid = 1'b0;
  logic [AW-1:0] a_addr  = '0;
  logic [DW-1:0] a_data  = '0;
  logic          a_ready;
  logic          b_valid = 1'b0;
  logic [AW-1:0] b_addr  = '0;
  logic [DW-1:0] b_data  = '0;
  logic          b_ready;
  logic          wr_enb;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] q1_addr = '0;
  logic          q1_hit;
  logic [DW-1:0] q1_data;
  logic [AW-1:0] q2_addr = '0;
  logic          q2_hit;
  logic [DW-1:0] q2_data;
  logic [CW-1:0] count;
  logic          empty;

  regfile_write_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .wr_enb(wr_enb), .wr_addr(wr_addr), .wr_data(wr_data),
    .q1_addr(q1_addr), .q1_hit(q1_hit), .q1_data(q1_data),
    .q2_addr(q2_addr), .q2_hit(q2_hit), .q2_data(q2_data),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t sb[$];
  ent_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   mcount   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // One clock cycle of stimulus; entered and left at posedge+1.
  task automatic step(input string tag,
                      input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                      output logic acc_a, output logic acc_b);
    int   fr;
    int   np;
    logic ea, eb, aenq;
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    @(negedge clk);
    fr   = DEPTH - mcount + ((mcount != 0) ? 1 : 0);
    ea   = (fr >= 1);
    aenq = av && ea && (aa != 0);
    eb   = (fr >= 2) || ((fr >= 1) && !aenq);
    chk({tag, " count"},   64'(count),   64'(mcount));
    chk({tag, " empty"},   64'(empty),   64'(mcount == 0));
    chk({tag, " wr_enb"},  64'(wr_enb),  64'(mcount != 0));
    chk({tag, " a_ready"}, 64'(a_ready), 64'(ea));
    chk({tag, " b_ready"}, 64'(b_ready), 64'(eb));
    np = 0;
    if (aenq) begin sb.push_back('{a: aa, d: ad}); np++; end
    if (bv && eb && (ba != 0)) begin sb.push_back('{a: ba, d: bd}); np++; end
    acc_a  = av && ea;
    acc_b  = bv && eb;
    mcount = mcount + np - ((mcount != 0) ? 1 : 0);
    @(posedge clk); #1;
  endtask

  task automatic idle(input string tag, input int n);
    logic x, y;
    for (int i = 0; i < n; i++) step(tag, 1'b0, '0, '0, 1'b0, '0, '0, x, y);
  endtask

  task automatic fwd(input string tag, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                     input logic h1, input logic [DW-1:0] d1,
                     input logic h2, input logic [DW-1:0] d2);
    q1_addr = a1; q2_addr = a2;
    #1;
    chk({tag, " q1_hit"},  64'(q1_hit),  64'(h1));
    chk({tag, " q1_data"}, 64'(q1_data), 64'(d1));
    chk({tag, " q2_hit"},  64'(q2_hit),  64'(h2));
    chk({tag, " q2_data"}, 64'(q2_data), 64'(d2));
  endtask

  task automatic do_reset();
    a_valid = 1'b0; b_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    mcount = 0;
  endtask

  // Monitor: every presented write must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_enb === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual addr=%0d data=%0h required=no write", wr_addr, wr_data);
        end else begin
          mon_e = sb.pop_front();
          chk("write addr", 64'(wr_addr), 64'(mon_e.a));
          chk("write data", 64'(wr_data), 64'(mon_e.d));
        end
      end else begin
        chk("idle wr_addr", 64'(wr_addr), 64'd0);
        chk("idle wr_data", 64'(wr_data), 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc_a, acc_b;
    int   ai, bi;
    repeat (2) @(posedge clk);
    #1;
    // Reset state.
    chk("reset count",   64'(count),   64'd0);
    chk("reset empty",   64'(empty),   64'd1);
    chk("reset wr_enb",  64'(wr_enb),  64'd0);
    chk("reset wr_addr", 64'(wr_addr), 64'd0);
    chk("reset wr_data", 64'(wr_data), 64'd0);
    fwd("reset fwd", 5'd5, 5'd3, 1'b0, 32'h0, 1'b0, 32'h0);
    rst = 1'b0;
    sb.delete();
    mcount = 0;

    // Single write: one-cycle latency, then empty again.
    step("single", 1'b1, 5'd5, 32'h0000_0009, 1'b0, '0, '0, acc_a, acc_b);
    idle("single drain", 2);

    // Dual push to the same register; newest value forwards.
    step("dual", 1'b1, 5'd3, 32'hAAAA_0001, 1'b1, 5'd3, 32'hBBBB_0002, acc_a, acc_b);
    fwd("dual both", 5'd3, 5'd3, 1'b1, 32'hBBBB_0002, 1'b1, 32'hBBBB_0002);
    idle("dual a", 1);
    fwd("dual mid", 5'd3, 5'd4, 1'b1, 32'hBBBB_0002, 1'b0, 32'h0);
    idle("dual b", 1);
    fwd("dual done", 5'd3, 5'd3, 1'b0, 32'h0, 1'b0, 32'h0);

    // Register 0 is consumed but dropped.
    step("reg0", 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, '0, '0, acc_a, acc_b);
    fwd("reg0 lookup", 5'd0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    idle("reg0 after", 2);

    // Backpressure: both producers every cycle, B holds until accepted.
    ai = 0; bi = 0;
    for (int c = 0; c < 10; c++) begin
      step("bp", 1'b1, AW'(ai + 1), 32'hA000_0000 + 32'(ai),
                 1'b1, AW'(bi + 17), 32'hB000_0000 + 32'(bi), acc_a, acc_b);
      if (acc_a) ai++;
      if (acc_b) bi++;
    end
    idle("bp drain", 5);

    // Forwarding newest: queue ends up (7,1),(7,2),(9,3).
    step("fw fill0", 1'b1, 5'd1, 32'd11, 1'b1, 5'd2, 32'd22, acc_a, acc_b);
    step("fw fill1", 1'b1, 5'd7, 32'd1,  1'b1, 5'd7, 32'd2,  acc_a, acc_b);
    step("fw fill2", 1'b1, 5'd9, 32'd3,  1'b0, '0, '0,      acc_a, acc_b);
    fwd("fw newest", 5'd7, 5'd9, 1'b1, 32'd2, 1'b1, 32'd3);
    fwd("fw miss",   5'd7, 5'd8, 1'b1, 32'd2, 1'b0, 32'h0);

    // Reset with three entries queued: all discarded, nothing stale written.
    do_reset();
    step("post reset", 1'b0, '0, '0, 1'b0, '0, '0, acc_a, acc_b);
    fwd("post reset fwd", 5'd7, 5'd9, 1'b0, 32'h0, 1'b0, 32'h0);
    idle("post reset idle", 3);
    step("after reset push", 1'b1, 5'd12, 32'h0000_1234, 1'b0, '0, '0, acc_a, acc_b);

    for (int i = 0; i < 20 && sb.size() > 0; i++) idle("final drain", 1);
    idle("final idle", 1);
    chk("scoreboard drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_write_queue.md
Name: regfile_write_queue

Overview:
- Write-side front end for the 32x32 register file; it is the only block that drives the register file's single write port (wr_enb, wr_addr, wr_data).
- Accepts results from two producers with valid/ready handshakes: port A (ALU) and port B (load/mem unit).
- Buffers accepted results in a small in-order FIFO and drains one register write per cycle.
- Provides two forwarding lookups so the read side can see values that are queued but not yet written.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- AW, 5, register address width.
- DW, 32, data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- a_valid  in  1  producer A has a result.
- a_addr  in  AW  destination register for A.
- a_data  in  DW  result value for A.
- a_ready  out  1  A's result is consumed this cycle when a_valid is also high.
- b_valid  in  1  producer B has a result.
- b_addr  in  AW  destination register for B.
- b_data  in  DW  result value for B.
- b_ready  out  1  B's result is consumed this cycle when b_valid is also high.
- wr_enb  out  1  register-file write enable.
- wr_addr  out  AW  register-file write address.
- wr_data  out  DW  register-file write data.
- q1_addr  in  AW  forwarding lookup 1 address.
- q1_hit  out  1  a queued entry matches q1_addr.
- q1_data  out  DW  data of the newest matching entry for lookup 1.
- q2_addr  in  AW  forwarding lookup 2 address.
- q2_hit  out  1  a queued entry matches q2_addr.
- q2_data  out  DW  data of the newest matching entry for lookup 2.
- count  out  log2(DEPTH)+1  current occupancy.
- empty  out  1  count == 0.

Behaviour:
- Reset, synchronous: count=0, head and tail pointers =0. wr_enb=0, q1_hit=0, q2_hit=0, empty=1. wr_addr, wr_data, q1_data and q2_data are 0 whenever there is no hit or valid head. Reset mid-traffic discards every queued entry; nothing is written that cycle.
- Drain:
  - wr_enb = !empty.
  - wr_addr and wr_data are driven combinationally from the head entry.
  - The head pops at every rising edge where wr_enb=1. The register file is never back-pressured.
- Free slots this cycle: free = DEPTH - count + (empty ? 0 : 1). This counts the slot freed by this cycle's pop.
- Ready rules:
  - a_ready = (free >= 1).
  - b_ready = (free >= 2) or (free >= 1 and A is not enqueuing this cycle).
  - A is enqueuing when a_valid & a_ready & (a_addr != 0).
  - b_ready therefore depends combinationally on a_valid and a_addr. This path is permitted.
- Enqueue:
  - On a consumed handshake with addr != 0, the entry {addr, data} is written at the tail.
  - If A and B are both enqueued in the same cycle, A is written first (older), then B.
  - count' = count + pushes - pop.
- Register 0 handling: a consumed handshake with addr == 0 completes normally (ready honoured) but is dropped. It does not enqueue and does not use a slot.
- Latency: a result consumed at edge N into an empty queue drives wr_enb from cycle N to N+1 and is written to the register file at edge N+1.
- Ordering: writes reach the register file in acceptance order. Two writes to the same register result in the later value being the final one.
- Forwarding:
  - A lookup hits on the newest valid entry, head included, whose addr equals the lookup address. The head counts because the register file has not yet captured it.
  - A lookup of addr 0 never hits.
  - Results being accepted in the same cycle are not visible to lookups; they become visible the next cycle.
  - The lookups are purely combinational over the queue contents.
- Pointer wrap: head and tail wrap modulo DEPTH. Full and empty are derived from count, never from pointer equality alone.
- When full with no pop: impossible while count > 0, because a pop occurs every non-empty cycle. Full means free = 1.

Test Plan:
- Single write: after reset, A pushes addr 5 / 0x0000_0009 -> next cycle wr_enb=1, wr_addr=5, wr_data=9; the following cycle empty=1.
- Dual push: A (3, 0xAAAA_0001) and B (3, 0xBBBB_0002) in the same cycle -> both ready; writes in order A then B; q1_addr=3 in the intermediate cycle returns hit=1, data=0xBBBB_0002.
- Register 0: A pushes addr 0 / 0xDEAD_BEEF -> a_ready=1, count stays 0, wr_enb never asserted; q1_addr=0 gives q1_hit=0.
- Backpressure: A and B push every cycle with distinct addresses for 10 cycles -> count saturates at DEPTH; b_ready=0 whenever free=1 and A is enqueuing; all accepted writes appear in order with none lost or duplicated; pointers wrap.
- Forwarding newest: queue holds (7, 1), (7, 2), (9, 3) -> q1_addr=7 gives 2; q2_addr=9 gives 3; q2_addr=8 gives hit=0.
- Reset mid-traffic: assert rst with count=3 -> next cycle count=0, wr_enb=0, a_ready=b_ready=1, and no stale writes appear afterwards.
